// File: rtl/rmt_cmd_issuer.sv
// Command issuer on the remote-controller side of the quadcopter link.
// Takes one command (opcode + 16-bit data), sends it to a UART transmitter
// as three bytes (opcode, data high, data low), then waits for a single
// response byte from a UART receiver. The wait is bounded by a timer whose
// limit depends on the opcode: calibration gets a much longer window because
// the airframe spins the motors up before answering.
module rmt_cmd_issuer #(
    parameter int RESP_TMO = 1_000_000,   // response window, normal opcodes
    parameter int CAL_TMO  = 100_000_000, // response window, CALIBRATE
    parameter int TMR_W    = 27           // must hold max(RESP_TMO, CAL_TMO)
) (
    input  logic        clk,
    input  logic        rst,
    // command request from the remote's control logic
    input  logic        snd_cmd,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    // UART transmitter side
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    // UART receiver side
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    // response / status
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        ack_err,
    output logic        timeout,
    output logic        busy
);

    localparam logic [7:0] OP_REQ_BATT = 8'h01;
    localparam logic [7:0] OP_CAL      = 8'h06;
    localparam logic [7:0] ACK_BYTE    = 8'hA5;

    // Last timer value that still counts as "in time"; the state is left on
    // the cycle the timer reaches it, so the timeout pulse lands exactly
    // <limit> cycles after the response window opens.
    localparam logic [TMR_W-1:0] RESP_LAST = TMR_W'(RESP_TMO - 1);
    localparam logic [TMR_W-1:0] CAL_LAST  = TMR_W'(CAL_TMO - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TX_CMD    = 3'd1,
        TX_HI     = 3'd2,
        TX_LO     = 3'd3,
        WAIT_RESP = 3'd4
    } state_t;

    state_t            state_q,    state_d;
    logic [7:0]        cmd_q,      cmd_d;
    logic [15:0]       data_q,     data_d;
    logic [7:0]        tx_data_q,  tx_data_d;
    logic              trmt_q,     trmt_d;
    logic [7:0]        resp_q,     resp_d;
    logic              resp_rdy_q, resp_rdy_d;
    logic              ack_err_q,  ack_err_d;
    logic              timeout_q,  timeout_d;
    logic [TMR_W-1:0]  timer_q,    timer_d;

    logic [TMR_W-1:0]  tmr_last;
    logic              tmr_expired;
    logic              clr_rx;

    // Response window end chosen from the latched opcode, not the live input.
    always_comb begin
        tmr_last    = (cmd_q == OP_CAL) ? CAL_LAST : RESP_LAST;
        tmr_expired = (timer_q >= tmr_last);
    end

    // Next-state and output decode for the issue/wait sequence.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        tx_data_d  = tx_data_q;
        trmt_d     = 1'b0;
        resp_d     = resp_q;
        resp_rdy_d = 1'b0;
        ack_err_d  = ack_err_q;
        timeout_d  = 1'b0;
        timer_d    = timer_q;
        clr_rx     = 1'b0;

        case (state_q)
            IDLE: begin
                // Anything sitting in the receiver while idle is a leftover
                // from an earlier exchange; drop it.
                if (rx_rdy) begin
                    clr_rx = 1'b1;
                end
                if (snd_cmd) begin
                    cmd_d     = cmd;
                    data_d    = data;
                    ack_err_d = 1'b0;
                    tx_data_d = cmd;
                    trmt_d    = 1'b1;
                    state_d   = TX_CMD;
                end
            end

            TX_CMD: begin
                if (tx_done) begin
                    tx_data_d = data_q[15:8];
                    trmt_d    = 1'b1;
                    state_d   = TX_HI;
                end
            end

            TX_HI: begin
                if (tx_done) begin
                    tx_data_d = data_q[7:0];
                    trmt_d    = 1'b1;
                    state_d   = TX_LO;
                end
            end

            TX_LO: begin
                // The response window opens once the last byte is out.
                if (tx_done) begin
                    timer_d = '0;
                    state_d = WAIT_RESP;
                end
            end

            WAIT_RESP: begin
                // A byte arriving on the final cycle still counts: the
                // response check has priority over expiry.
                if (rx_rdy) begin
                    clr_rx     = 1'b1;
                    resp_d     = rx_data;
                    resp_rdy_d = 1'b1;
                    ack_err_d  = (cmd_q != OP_REQ_BATT) && (rx_data != ACK_BYTE);
                    state_d    = IDLE;
                end else if (tmr_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any exchange in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= 8'h00;
            data_q     <= 16'h0000;
            tx_data_q  <= 8'h00;
            trmt_q     <= 1'b0;
            resp_q     <= 8'h00;
            resp_rdy_q <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            tx_data_q  <= tx_data_d;
            trmt_q     <= trmt_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
            ack_err_q  <= ack_err_d;
            timeout_q  <= timeout_d;
            timer_q    <= timer_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign trmt       = trmt_q;
    assign resp       = resp_q;
    assign resp_rdy   = resp_rdy_q;
    assign ack_err    = ack_err_q;
    assign timeout    = timeout_q;
    assign clr_rx_rdy = clr_rx;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rmt_cmd_issuer.sv
// Bench for rmt_cmd_issuer: a UART stand-in answers each trmt with tx_done
// after a programmable delay, a monitor logs every transmitted byte, and each
// scenario task drives commands/responses and checks outcomes computed from
// the command-link rules (byte order, ack rule, response window per opcode).
module tb_rmt_cmd_issuer;

    localparam int RESP_TMO = 50;
    localparam int CAL_TMO  = 500;

    logic        clk = 1'b0;
    logic        rst;
    logic        snd_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        ack_err;
    logic        timeout;
    logic        busy;

    rmt_cmd_issuer #(
        .RESP_TMO (RESP_TMO),
        .CAL_TMO  (CAL_TMO),
        .TMR_W    (27)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .snd_cmd    (snd_cmd),
        .cmd        (cmd),
        .data       (data),
        .tx_data    (tx_data),
        .trmt       (trmt),
        .tx_done    (tx_done),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .resp       (resp),
        .resp_rdy   (resp_rdy),
        .ack_err    (ack_err),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int          dly = 10;      // tx_done delay after each trmt
    logic [7:0]  exp_resp = 8'h00;

    logic [7:0]  log_b[$];
    int          log_c[$];
    int          resp_cnt = 0;
    int          tmo_cnt  = 0;

    // Monitor: sample outputs mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (trmt === 1'b1) begin
                log_b.push_back(tx_data);
                log_c.push_back(cyc);
            end
            if (resp_rdy === 1'b1) resp_cnt++;
            if (timeout === 1'b1) tmo_cnt++;
        end
    end

    // UART transmitter stand-in: tx_done one cycle, dly cycles after trmt.
    initial begin
        int rcnt;
        rcnt = 0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (trmt === 1'b1) begin
                rcnt = dly;
            end else if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) tx_done = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full command exchange. give=0 means no response (expect timeout);
    // r is the response cycle counted from the first waiting cycle.
    task automatic run_txn(input logic [7:0] c, input logic [15:0] d,
                           input bit give, input int r, input logic [7:0] rb,
                           input bit poke);
        int   base, lim, e, t, rc0, tc0;
        bit   poked;
        logic exp_ack;
        logic [7:0] exp_b[3];
        exp_b[0] = c;
        exp_b[1] = d[15:8];
        exp_b[2] = d[7:0];
        lim     = (c == 8'h06) ? CAL_TMO : RESP_TMO;
        exp_ack = (c != 8'h01) && (rb != 8'hA5);
        poked   = 1'b0;

        t = 0;
        while (busy !== 1'b0 && t < 2000) begin step(); t++; end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL idle_wait: busy=%b want 0", busy); return;
        end

        base = log_b.size();
        rc0  = resp_cnt;
        tc0  = tmo_cnt;
        snd_cmd = 1'b1; cmd = c; data = d;
        step();
        snd_cmd = 1'b0; cmd = 8'($urandom); data = 16'($urandom);
        total++; if (trmt !== 1'b1) begin bad++; $display("FAIL first_trmt: got %b want 1", trmt); end
        total++; if (tx_data !== c) begin bad++; $display("FAIL first_byte: got %h want %h", tx_data, c); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_on: got %b want 1", busy); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL ack_clr: got %b want 0", ack_err); end

        t = 0;
        while (log_b.size() < base + 3 && t < 200) begin
            if (poke && !poked && log_b.size() == base + 2) begin
                snd_cmd = 1'b1; cmd = 8'($urandom_range(1, 8)); data = 16'($urandom);
                poked = 1'b1;
            end else begin
                snd_cmd = 1'b0;
            end
            step();
            t++;
        end
        snd_cmd = 1'b0;
        total++;
        if (log_b.size() < base + 3) begin
            bad++; $display("FAIL byte_count: got %0d want 3", log_b.size() - base); return;
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (log_b[base+i] !== exp_b[i]) begin
                bad++; $display("FAIL byte%0d: got %h want %h", i, log_b[base+i], exp_b[i]);
            end
        end

        e = log_c[base+2] + dly + 1;
        if (give) begin
            while (cyc < e + r) step();
            rx_rdy = 1'b1; rx_data = rb;
            #1;
            total++; if (clr_rx_rdy !== 1'b1) begin bad++; $display("FAIL clr_wait: got %b want 1", clr_rx_rdy); end
            step();
            rx_rdy = 1'b0; rx_data = 8'($urandom);
            total++; if (resp_rdy !== 1'b1) begin bad++; $display("FAIL resp_rdy: got %b want 1", resp_rdy); end
            total++; if (resp !== rb) begin bad++; $display("FAIL resp: got %h want %h", resp, rb); end
            total++; if (ack_err !== exp_ack) begin bad++; $display("FAIL ack_err: got %b want %b", ack_err, exp_ack); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_off: got %b want 0", busy); end
            total++; if (timeout !== 1'b0) begin bad++; $display("FAIL no_tmo: got %b want 0", timeout); end
            exp_resp = rb;
            step();
            total++; if (resp_rdy !== 1'b0) begin bad++; $display("FAIL resp_rdy_width: got %b want 0", resp_rdy); end
            total++; if (ack_err !== exp_ack) begin bad++; $display("FAIL ack_hold: got %b want %b", ack_err, exp_ack); end
        end else begin
            t = 0;
            while (timeout !== 1'b1 && t < lim + 60) begin step(); t++; end
            total++;
            if (timeout !== 1'b1) begin
                bad++; $display("FAIL tmo_seen: got 0 want 1");
            end else begin
                total++; if (cyc !== e + lim) begin bad++; $display("FAIL tmo_cycle: got %0d want %0d", cyc - e, lim); end
                total++; if (resp !== exp_resp) begin bad++; $display("FAIL resp_kept: got %h want %h", resp, exp_resp); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_tmo: got %b want 0", busy); end
            end
            step();
            total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_width: got %b want 0", timeout); end
        end
        total++; if (log_b.size() !== base + 3) begin bad++; $display("FAIL extra_bytes: got %0d want 3", log_b.size() - base); end
        total++; if (resp_cnt - rc0 !== (give ? 1 : 0)) begin bad++; $display("FAIL resp_pulses: got %0d want %0d", resp_cnt - rc0, give ? 1 : 0); end
        total++; if (tmo_cnt - tc0 !== (give ? 0 : 1)) begin bad++; $display("FAIL tmo_pulses: got %0d want %0d", tmo_cnt - tc0, give ? 0 : 1); end
        $display("txn cmd=%h data=%h resp=%0s%h r=%0d dly=%0d poke=%0d", c, d,
                 give ? "" : "none/", rb, r, dly, poke);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        total++; if (trmt !== 1'b0) begin bad++; $display("FAIL rst_trmt: got %b want 0", trmt); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        total++; if (resp !== 8'h00) begin bad++; $display("FAIL rst_resp: got %h want 00", resp); end
        total++; if ({resp_rdy, ack_err, timeout, busy, clr_rx_rdy} !== 5'b0) begin
            bad++; $display("FAIL rst_flags: got %b want 00000", {resp_rdy, ack_err, timeout, busy, clr_rx_rdy});
        end
        rst = 1'b0;
        step();
        $display("txn reset");
    endtask

    task automatic test_set_ptch();
        dly = 10;
        run_txn(8'h02, 16'h1234, 1'b1, 7, 8'hA5, 1'b0);
    endtask

    task automatic test_req_batt();
        dly = 10;
        run_txn(8'h01, 16'h0000, 1'b1, 3, 8'hC3, 1'b0);
    endtask

    task automatic test_nack();
        dly = 4;
        run_txn(8'h05, 16'hBEEF, 1'b1, 12, 8'h5A, 1'b0);
        repeat (3) step();
        total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL nack_hold: got %b want 1", ack_err); end
        // next command clears it (checked inside run_txn right after accept)
        run_txn(8'h07, 16'h00FF, 1'b1, 0, 8'hA5, 1'b0);
    endtask

    task automatic test_timeout();
        dly = 5;
        run_txn(8'h03, 16'h4321, 1'b0, 0, 8'h00, 1'b0);
        run_txn(8'h03, 16'h8001, 1'b1, RESP_TMO - 1, 8'hA5, 1'b0);
    endtask

    task automatic test_calibrate();
        dly = 6;
        run_txn(8'h06, 16'h0000, 1'b1, 300, 8'hA5, 1'b0);
        run_txn(8'h06, 16'h0102, 1'b1, CAL_TMO - 1, 8'h77, 1'b0);
        run_txn(8'h06, 16'h0304, 1'b0, 0, 8'h00, 1'b0);
    endtask

    task automatic test_busy_ignore();
        dly = 8;
        run_txn(8'h04, 16'hCAFE, 1'b1, 5, 8'hA5, 1'b1);
    endtask

    task automatic test_stale_rx();
        int rc0;
        rc0 = resp_cnt;
        rx_rdy = 1'b1; rx_data = 8'h99;
        #1;
        total++; if (clr_rx_rdy !== 1'b1) begin bad++; $display("FAIL stale_clr: got %b want 1", clr_rx_rdy); end
        step();
        rx_rdy = 1'b0;
        repeat (3) step();
        total++; if (resp_cnt !== rc0) begin bad++; $display("FAIL stale_resp_rdy: got %0d want %0d", resp_cnt - rc0, 0); end
        total++; if (resp !== exp_resp) begin bad++; $display("FAIL stale_resp: got %h want %h", resp, exp_resp); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stale_busy: got %b want 0", busy); end
        $display("txn stale rx byte 99");
    endtask

    task automatic test_reset_mid();
        int base, t;
        dly = 10;
        base = log_b.size();
        snd_cmd = 1'b1; cmd = 8'h02; data = 16'h5566;
        step();
        snd_cmd = 1'b0;
        t = 0;
        while (log_b.size() < base + 2 && t < 100) begin step(); t++; end
        total++;
        if (log_b.size() < base + 2) begin
            bad++; $display("FAIL mid_reach_hi: got %0d want 2", log_b.size() - base);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (trmt !== 1'b0) begin bad++; $display("FAIL mid_trmt: got %b want 0", trmt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
        total++; if (resp !== 8'h00) begin bad++; $display("FAIL mid_resp: got %h want 00", resp); end
        exp_resp = 8'h00;
        repeat (25) step();
        total++; if (log_b.size() !== base + 2) begin bad++; $display("FAIL mid_late_done: got %0d want 2", log_b.size() - base); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_idle: got %b want 0", busy); end
        $display("txn reset during TX_HI");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic [7:0]  c;
            logic [15:0] d;
            logic [7:0]  rb;
            bit          give;
            int          lim, r;
            c    = 8'($urandom_range(1, 8));
            d    = 16'($urandom);
            rb   = ($urandom_range(0, 1) == 0) ? 8'hA5 : 8'($urandom);
            give = ($urandom_range(0, 3) != 0);
            lim  = (c == 8'h06) ? CAL_TMO : RESP_TMO;
            r    = $urandom_range(0, lim - 1);
            dly  = $urandom_range(2, 12);
            run_txn(c, d, give, r, rb, $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        rst = 1'b1; snd_cmd = 1'b0; cmd = 8'h00; data = 16'h0000;
        rx_rdy = 1'b0; rx_data = 8'h00;
        test_reset();
        test_set_ptch();
        test_req_batt();
        test_nack();
        test_timeout();
        test_calibrate();
        test_busy_ignore();
        test_stale_rx();
        test_reset_mid();
        test_random();
        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so a stuck design can never hang the run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
